// File: rtl/button_press_pkg.sv
// Shared types and LFSR constants for the push-button waveform generator.
package button_press_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BOUNCE  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } press_state_t;

  typedef enum logic {
    PRESS_SHORT = 1'b0,
    PRESS_LONG  = 1'b1
  } press_kind_t;

  // x^8+x^6+x^5+x^4+1, left-shifting Fibonacci form: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// Deterministic contact-bounce source; bit_out is the level to present next cycle.
module bounce_lfsr
  import button_press_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic bit_out
);

  logic [7:0] lfsr;
  logic [7:0] lfsr_nxt;

  assign lfsr_nxt = lfsr_step(lfsr);
  // On load the seed's own bit is shown first, then one step per cycle
  assign bit_out  = load ? LFSR_SEED[0] : lfsr_nxt[0];

  always_ff @(posedge clk) begin
    if (rst || load) lfsr <= LFSR_SEED;
    else             lfsr <= lfsr_nxt;
  end

endmodule

// File: rtl/button_press_gen.sv
// Turns short/long press commands into a timed push_button level.
// Optional bounce emulation: define BUTTON_PRESS_GEN_BOUNCE_EN.
module button_press_gen
  import button_press_pkg::*;
#(
  parameter int DEBOUNCE_P        = 300,
  parameter int SWITCH_MODE_MIN_T = 5000,
  parameter int SHORT_HOLD_T      = 1000,
  parameter int LONG_HOLD_T       = 6000,
  parameter int RELEASE_T         = 100,
  parameter int BOUNCE_LEN        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_long,
  output logic cmd_ready,
  output logic push_button,
  output logic done
);

  localparam int MAX_A = (LONG_HOLD_T > RELEASE_T) ? LONG_HOLD_T : RELEASE_T;
  localparam int MAX_N = (MAX_A > BOUNCE_LEN) ? MAX_A : BOUNCE_LEN;
  localparam int CW    = $clog2(MAX_N + 1);

  localparam logic [CW-1:0] SHORT_C = CW'(SHORT_HOLD_T - 1);
  localparam logic [CW-1:0] LONG_C  = CW'(LONG_HOLD_T - 1);
  localparam logic [CW-1:0] REL_C   = CW'(RELEASE_T - 1);

  if (!(DEBOUNCE_P < SHORT_HOLD_T && SHORT_HOLD_T < SWITCH_MODE_MIN_T)) begin : g_bad_short
    $fatal(1, "SHORT_HOLD_T must lie strictly between DEBOUNCE_P and SWITCH_MODE_MIN_T");
  end
  if (!(LONG_HOLD_T > SWITCH_MODE_MIN_T)) begin : g_bad_long
    $fatal(1, "LONG_HOLD_T must exceed SWITCH_MODE_MIN_T");
  end
  if (RELEASE_T < 1) begin : g_bad_rel
    $fatal(1, "RELEASE_T must be at least 1");
  end

  press_state_t  state, nstate;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done_nxt, pb_nxt, accept;

  assign accept    = cmd_valid && (state == IDLE);
  assign cmd_ready = (state == IDLE) && !rst;

`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
  press_kind_t kind, kind_nxt;
  logic        bounce_bit;

  bounce_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .bit_out (bounce_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) kind <= PRESS_SHORT;
    else     kind <= kind_nxt;
  end
`endif

  always_comb begin
    nstate   = state;
    cnt_nxt  = (cnt != '0) ? cnt - CW'(1) : cnt;
    done_nxt = 1'b0;
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
    kind_nxt = kind;
`endif
    case (state)
      IDLE: if (accept) begin
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
        kind_nxt = press_kind_t'(cmd_long);
        nstate   = BOUNCE;
        cnt_nxt  = CW'(BOUNCE_LEN - 1);
`else
        nstate   = HOLD;
        cnt_nxt  = cmd_long ? LONG_C : SHORT_C;
`endif
      end
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
      BOUNCE: if (cnt == '0) begin
        nstate  = HOLD;
        cnt_nxt = (kind == PRESS_LONG) ? LONG_C : SHORT_C;
      end
`endif
      HOLD: if (cnt == '0) begin
        nstate  = RELEASE;
        cnt_nxt = REL_C;
      end
      RELEASE: if (cnt == '0) begin
        nstate   = IDLE;
        done_nxt = 1'b1;
      end
      default: nstate = IDLE;
    endcase

    // Output is registered from the next state so it lines up with the state
    case (nstate)
      HOLD:    pb_nxt = 1'b1;
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
      BOUNCE:  pb_nxt = bounce_bit;
`endif
      default: pb_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      push_button <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= nstate;
      cnt         <= cnt_nxt;
      push_button <= pb_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_button_press_gen.sv
// Self-checking bench for button_press_gen: vector table, corner sequences, random vs timeline model.
module tb_button_press_gen;

  localparam int DP = 3, SM = 20, SH = 8, LH = 25, RL = 4, BL = 6;
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
  localparam int B = BL;
`else
  localparam int B = 0;
`endif

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_long;
  logic cmd_ready, push_button, done;

  int total = 0;
  int bad   = 0;

  button_press_gen #(
    .DEBOUNCE_P(DP), .SWITCH_MODE_MIN_T(SM), .SHORT_HOLD_T(SH),
    .LONG_HOLD_T(LH), .RELEASE_T(RL), .BOUNCE_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_long(cmd_long),
    .cmd_ready(cmd_ready), .push_button(push_button), .done(done)
  );

  always #5 clk = ~clk;

  // Timeline model: cycles elapsed since the accepting edge decide every output
  bit m_busy = 0;
  int m_t = 0;
  int m_h = SH;
  bit exp_pb, exp_done, exp_rdy;
  bit bbit [0:15];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input bit l);
    exp_done = 0;
    exp_pb   = 0;
    if (r) m_busy = 0;
    else if (!m_busy && v) begin
      m_busy = 1; m_t = 0; m_h = l ? LH : SH;
    end
    if (m_busy) begin
      m_t++;
      if (m_t <= B) exp_pb = bbit[m_t];
      else          exp_pb = (m_t <= B + m_h);
      if (m_t == B + m_h + RL + 1) begin
        exp_done = 1; m_busy = 0;
      end
    end
    exp_rdy = !m_busy && !r;
  endtask

  task automatic step(input bit r, input bit v, input bit l, input bit check);
    rst = r; cmd_valid = v; cmd_long = l;
    @(posedge clk);
    model_edge(r, v, l);
    #1;
    if (check) begin
      chk("model_pb",    push_button, exp_pb);
      chk("model_done",  done,        exp_done);
      chk("model_ready", cmd_ready,   exp_rdy);
    end
  endtask

  typedef struct {
    bit r, v, l;
    bit pb, dn, rdy;
  } vec_t;

  initial begin : main
    vec_t vecs[$];
    vec_t vv;
    int   done_cyc[$];
    int   ndone;
    logic [7:0] s;

    s = 8'hA5;
    for (int k = 1; k <= 15; k++) begin
      bbit[k] = s[0];
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    bbit[0] = 0;

    // Reset state
    rst = 1; cmd_valid = 1; cmd_long = 0;
    @(posedge clk); model_edge(1, 1, 0); #1;
    chk("rst_pb", push_button, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 0);

    // Short press table: accept at E0, then cycles 1..B+H+R+1
    vv = '{r:0, v:1, l:0, pb:(B == 0) ? 1'b1 : bbit[1], dn:0, rdy:0};
    vecs.push_back(vv);
    for (int k = 2; k <= B + SH + RL + 1; k++) begin
      vv.r = 0; vv.v = 0; vv.l = 0;
      vv.pb  = (k <= B) ? bbit[k] : (k <= B + SH);
      vv.dn  = (k == B + SH + RL + 1);
      vv.rdy = (k == B + SH + RL + 1);
      vecs.push_back(vv);
    end
    rst = 0; cmd_valid = 0; #1;
    chk("ready_after_rst", cmd_ready, 1);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].v, vecs[i].l, 0);
      chk($sformatf("vec%0d_pb", i + 1), push_button, vecs[i].pb);
      chk($sformatf("vec%0d_done", i + 1), done, vecs[i].dn);
      chk($sformatf("vec%0d_ready", i + 1), cmd_ready, vecs[i].rdy);
    end
    step(0, 0, 0, 0);
    chk("done_one_cycle", done, 0);

    // Long press: exactly LH high cycles, done at B+LH+RL+1
    begin
      int hi = 0, dcy = -1;
      step(0, 1, 1, 0);
      for (int k = 1; k <= B + LH + RL + 3; k++) begin
        if (k > 1) step(0, 0, 0, 0);
        if (k > B && push_button) hi++;
        if (done && dcy < 0) dcy = k;
      end
      chk("long_high_cycles", hi, LH);
      chk("long_done_cycle", dcy, B + LH + RL + 1);
    end

    // cmd_valid held: presses repeat at the minimum period
    ndone = 0;
    for (int k = 1; k <= 3 * (B + SH + RL + 1) + 2; k++) begin
      step(0, 1, 0, 1);
      if (done) done_cyc.push_back(k);
    end
    chk("held_done_count", done_cyc.size(), 3);
    if (done_cyc.size() >= 2) chk("held_period", done_cyc[1] - done_cyc[0], B + SH + RL + 1);
    else chk("held_period", 0, B + SH + RL + 1);
    step(0, 0, 0, 1);
    repeat (B + SH + RL + 2) step(0, 0, 0, 1);

    // Reset during cycle 10 of a long press
    step(0, 1, 1, 1);
    for (int k = 2; k <= 9; k++) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("abort_pb", push_button, 0);
    chk("abort_ready", cmd_ready, 0);
    step(0, 0, 0, 1);
    chk("abort_ready_after", cmd_ready, 1);
    for (int k = 0; k < 40; k++) begin
      step(0, 0, 0, 1);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // Simultaneous rst and cmd_valid: nothing starts
    step(1, 1, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_wins_pb", push_button, 0);

    // Random traffic against the timeline model
    for (int k = 0; k < 1500; k++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_press_gen.md
# button_press_gen

Synthesises push-button waveforms on command: a requested short or long press is turned into a single-wire active-high `push_button` level with hold times that land unambiguously inside the debouncer/classifier windows. It is the transmitting end of the push-button interface and drives the classifier's `push_button` input for self-test and remote actuation. Optional contact-bounce emulation exercises the debounce path.

## Interface
- `DEBOUNCE_P`, 300: debounce window of the downstream classifier, in cycles; used only for the legality check.
- `SWITCH_MODE_MIN_T`, 5000: classifier long-press threshold, in cycles.
- `SHORT_HOLD_T`, 1000: high time of a short press, in cycles; must satisfy `DEBOUNCE_P < SHORT_HOLD_T < SWITCH_MODE_MIN_T`.
- `LONG_HOLD_T`, 6000: high time of a long press, in cycles; must satisfy `LONG_HOLD_T > SWITCH_MODE_MIN_T`.
- `RELEASE_T`, 100: forced low time after each press, in cycles; must be ≥ 1.
- `BOUNCE_LEN`, 16: bounce-phase length in cycles; used only with `BOUNCE_EN`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: a press request is present.
- `cmd_long` in 1: 1 selects a long press and 0 a short press; qualified by `cmd_valid`.
- `cmd_ready` out 1: generator is idle and accepts a command.
- `push_button` out 1: synthesised button level; registered.
- `done` out 1: one-cycle pulse when a press, including its release gap, has completed.

## Operation
- States: `IDLE`, `BOUNCE`, `HOLD`, `RELEASE`.
  - `BOUNCE` exists only with `BOUNCE_EN`.
- A command is accepted on a rising edge where `cmd_valid && cmd_ready`. `cmd_long` is latched at that edge.
  - Holding `cmd_valid` high in a state other than `IDLE` has no effect.
- Transitions:
  - `IDLE` → `BOUNCE` on accept when `BOUNCE_EN` is defined, otherwise `IDLE` → `HOLD`.
  - `BOUNCE` → `HOLD` after `BOUNCE_LEN` cycles.
  - `HOLD` → `RELEASE` after the hold time: `LONG_HOLD_T` if the latched `cmd_long` is 1, else `SHORT_HOLD_T`.
  - `RELEASE` → `IDLE` after `RELEASE_T` cycles.
- Outputs by state:
  - `push_button`: 1 in `HOLD`; 0 in `IDLE` and `RELEASE`; the bounce pattern in `BOUNCE`.
  - `cmd_ready`: 1 in `IDLE` only, and forced to 0 while `rst` is high.
- Counter:
  - One shared down-counter, width `$clog2(max(LONG_HOLD_T, RELEASE_T, BOUNCE_LEN)+1)`.
  - Loaded with `N-1` on entry to each timed state; the state exits when the counter reads 0. No wrap-around is possible.
- Parameter legality is checked at elaboration. A violated inequality is a fatal elaboration error.

## Timing
- Reset values: `push_button`=0, `done`=0, `cmd_ready`=0 while `rst`=1; state `IDLE`.
  - `cmd_ready`=1 in the first cycle after `rst` falls.
- Accept at edge E0 with H = hold time and R = `RELEASE_T`:
  - `push_button`=1 in cycles 1..H after E0, without `BOUNCE_EN`.
  - `push_button`=0 in cycles H+1..H+R.
  - Cycle H+R+1 after E0: `done`=1 for exactly one cycle, and `cmd_ready`=1 in the same cycle.
- With `BOUNCE_EN`, `BOUNCE_LEN` bounce cycles precede the H solid-high cycles. All later events shift by `BOUNCE_LEN`.
- Back-to-back commands:
  - A command accepted in the `done` cycle starts immediately.
  - The minimum period is `BOUNCE_LEN`+H+R+1 cycles (omit `BOUNCE_LEN` without `BOUNCE_EN`).
- Reset mid-press: at the next edge, `push_button`=0 and state is `IDLE`. No `done` is issued for the aborted press.
- Simultaneous `rst` and `cmd_valid`: reset wins and the command is not accepted.

## Configuration
- `BUTTON_PRESS_GEN_BOUNCE_EN` defined:
  - The `BOUNCE` state is compiled in.
  - An 8-bit LFSR (polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5) is reloaded on every accept and steps once per cycle.
  - `push_button` = LFSR bit 0 during `BOUNCE`, so the pattern is deterministic.
- `BUTTON_PRESS_GEN_BOUNCE_EN` undefined:
  - No LFSR and no `BOUNCE` state.
  - `push_button` is a clean edge; `BOUNCE_LEN` is ignored.

## Structure
- Package `button_press_pkg`:
  - state enum `press_state_t`;
  - LFSR seed and tap constants;
  - `press_kind_t` (`PRESS_SHORT`, `PRESS_LONG`).
- Sub-module `bounce_lfsr`, instantiated only under the macro. Ports: `clk`, `rst`, `load`, `bit_out`.

## Test plan
All scenarios use `DEBOUNCE_P`=3, `SWITCH_MODE_MIN_T`=20, `SHORT_HOLD_T`=8, `LONG_HOLD_T`=25, `RELEASE_T`=4, `BOUNCE_LEN`=6.
- Short command at E0, no macro → `push_button` high in cycles 1–8, low in 9–12; `done` and `cmd_ready` high at cycle 13.
- Long command → `push_button` high for exactly 25 cycles; `done` at cycle 30.
- `cmd_valid` held high continuously with `cmd_long`=0 → presses repeat every 13 cycles; a second command asserted mid-press is not accepted early.
- `rst` asserted at cycle 10 of a long press → `push_button`=0 at the next edge; no `done`; `cmd_ready`=1 one cycle after `rst` falls.
- Macro defined, short command → cycles 1–6 follow the LFSR bit-0 sequence from seed A5, identical on repeat; then 8 solid high cycles; `done` at cycle 19.
- Loopback into the classifier with the same parameters → a short command yields exactly one `B` event and a long command exactly one `A` event.
